// File: rtl/hcv_pkg.sv
// hcv_pkg: shared constants, types and helpers for the hcv frame-buffer
// fill engine.
//   - default screen geometry (1024 x 768)
//   - address / coordinate / colour widths
//   - fill FSM state encoding and latched command record
//   - pixel address packing {y, x}, identical to the display scan order
package hcv_pkg;

   localparam int HCV_H_RES = 1024;
   localparam int HCV_V_RES = 768;
   localparam int COORD_W   = 10;
   localparam int DIM_W     = 11;
   localparam int ADDR_W    = 20;
   localparam int COLOR_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fill_state_t;

   // Command captured on start; everything downstream works from this copy
   // so the CPU registers may change while a fill is running.
   typedef struct packed {
      logic [COORD_W-1:0] x0;
      logic [COORD_W-1:0] y0;
      logic [DIM_W-1:0]   w;
      logic [DIM_W-1:0]   h;
      logic [COLOR_W-1:0] color;
      logic               outline;
   } fill_cmd_t;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/hcv_fill_clip.sv
// hcv_fill_clip: combinational screen clip of a fill rectangle.
//   in : x0, y0 (origin), w, h (size, 0..1024)
//   out: xl, xr, yt, yb (inclusive clipped bounds), empty (nothing to draw)
// Bounds are only meaningful when empty is low.
module hcv_fill_clip
   import hcv_pkg::*;
#(
   parameter int H_RES = HCV_H_RES,
   parameter int V_RES = HCV_V_RES
) (
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [DIM_W-1:0]   w,
   input  logic [DIM_W-1:0]   h,
   output logic [COORD_W-1:0] xl,
   output logic [COORD_W-1:0] xr,
   output logic [COORD_W-1:0] yt,
   output logic [COORD_W-1:0] yb,
   output logic               empty
);

   localparam logic [11:0] HR = 12'(H_RES);
   localparam logic [11:0] VR = 12'(V_RES);

   // 12-bit sums: 1023 + 1024 still fits, so the end never wraps.
   logic [11:0] xe, ye, xe_c, ye_c;

   assign xe   = {2'b00, x0} + {1'b0, w};
   assign ye   = {2'b00, y0} + {1'b0, h};
   assign xe_c = (xe > HR) ? HR : xe;
   assign ye_c = (ye > VR) ? VR : ye;

   assign xl = x0;
   assign yt = y0;
   assign xr = 10'(xe_c - 12'd1);
   assign yb = 10'(ye_c - 12'd1);

   assign empty = (w == '0) || (h == '0) ||
                  ({2'b00, x0} >= HR) || ({2'b00, y0} >= VR);

endmodule

// File: rtl/hcv_fill.sv
// hcv_fill: rectangle-fill master on the hcv frame-buffer bus.
// Writes every pixel of the screen-clipped rectangle in raster order,
// one transfer outstanding at a time.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : command strobe (accepted only when idle)
//   x0, y0, w, h    : rectangle origin and size
//   color           : 16-bit pixel value
//   busy, done      : command in progress / one-cycle completion pulse
//   pix_cnt         : pixels written by current or last command
//   stb, we, addr, data_out, ack : bus master port
// Build option HCV_FILL_OUTLINE_EN adds input 'outline': draw only the
// border of the clipped rectangle.
module hcv_fill
   import hcv_pkg::*;
#(
   parameter int H_RES = HCV_H_RES,
   parameter int V_RES = HCV_V_RES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [DIM_W-1:0]   w,
   input  logic [DIM_W-1:0]   h,
   input  logic [COLOR_W-1:0] color,
`ifdef HCV_FILL_OUTLINE_EN
   input  logic               outline,
`endif
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  pix_cnt,
   output logic               stb,
   output logic               we,
   output logic [ADDR_W-1:0]  addr,
   output logic [31:0]        data_out,
   input  logic               ack
);

   fill_state_t        state, state_nxt;
   fill_cmd_t          cmd_q;
   logic [COORD_W-1:0] cx, cy, xl, xr, yt, yb;
   logic               empty, col_last, row_last, interior, outline_in;

`ifdef HCV_FILL_OUTLINE_EN
   assign outline_in = outline;
`else
   assign outline_in = 1'b0;
`endif

   // Clip runs off the latched command, so its outputs are stable from
   // SETUP onward and need no extra registers.
   hcv_fill_clip #(.H_RES(H_RES), .V_RES(V_RES)) u_clip (
      .x0   (cmd_q.x0),
      .y0   (cmd_q.y0),
      .w    (cmd_q.w),
      .h    (cmd_q.h),
      .xl   (xl),
      .xr   (xr),
      .yt   (yt),
      .yb   (yb),
      .empty(empty)
   );

   assign col_last = (cx >= xr);
   assign row_last = (cy >= yb);
   // Outline rows between top and bottom only need their two end pixels.
   assign interior = cmd_q.outline && (cy != yt) && (cy != yb);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETUP;
         SETUP:   state_nxt = empty ? DONE : WRITE;
         WRITE:   if (ack && col_last && row_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q   <= '0;
         pix_cnt <= '0;
         cx      <= '0;
         cy      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cmd_q   <= '{x0: x0, y0: y0, w: w, h: h, color: color,
                            outline: outline_in};
               pix_cnt <= '0;
            end
            SETUP: begin
               cx <= xl;
               cy <= yt;
            end
            WRITE: if (ack) begin
               pix_cnt <= pix_cnt + 1'b1;
               if (!col_last) begin
                  cx <= interior ? xr : cx + 1'b1;
               end else if (!row_last) begin
                  cx <= xl;
                  cy <= cy + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign stb      = (state == WRITE);
   assign we       = stb;
   assign addr     = pix_addr(cy, cx);
   assign data_out = {16'h0000, cmd_q.color};

endmodule

// File: tb/tb_hcv_fill.sv
module tb_hcv_fill;

   localparam int H = 1024;
   localparam int V = 768;
`ifdef HCV_FILL_OUTLINE_EN
   localparam bit HAS_OL = 1'b1;
`else
   localparam bit HAS_OL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, ack, outline;
   logic [9:0]  x0, y0;
   logic [10:0] w, h;
   logic [15:0] color;
   logic        busy, done, stb, we;
   logic [19:0] pix_cnt, addr;
   logic [31:0] data_out;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hcv_fill dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
`ifdef HCV_FILL_OUTLINE_EN
      .outline(outline),
`endif
      .busy(busy), .done(done), .pix_cnt(pix_cnt),
      .stb(stb), .we(we), .addr(addr), .data_out(data_out), .ack(ack)
   );

   // results of the last drive_fill
   logic [19:0] got_a[$];
   logic [31:0] got_d[$];
   logic [19:0] exp_a[$];
   int r_done_k, r_stb_cyc, r_busy_cyc, r_unstable, r_we_bad;
   logic r_done_w, r_idle_busy;
   bit r_tmo;

   // Reference: raster walk over the clipped rectangle.
   task automatic model(input int xv, input int yv, input int wv, input int hv, input bit ol);
      int xe, ye;
      exp_a.delete();
      if (wv == 0 || hv == 0 || xv >= H || yv >= V) return;
      xe = (xv + wv > H) ? H : xv + wv;
      ye = (yv + hv > V) ? V : yv + hv;
      for (int yy = yv; yy < ye; yy++)
         for (int xx = xv; xx < xe; xx++)
            if (!ol || yy == yv || yy == ye - 1 || xx == xv || xx == xe - 1)
               exp_a.push_back({yy[9:0], xx[9:0]});
   endtask

   // Bus slave + command driver; acks each pixel in its lat-th stb cycle.
   task automatic drive_fill(input int xv, input int yv, input int wv, input int hv,
                             input logic [15:0] cv, input bit ol, input int lat, input bit poke);
      int k, wc;
      logic [19:0] ha;
      logic [31:0] hd;
      got_a.delete(); got_d.delete();
      r_done_k = 0; r_stb_cyc = 0; r_busy_cyc = 0; r_unstable = 0; r_we_bad = 0;
      r_tmo = 0; wc = 0; ha = '0; hd = '0;
      @(negedge clk);
      x0 = 10'(xv); y0 = 10'(yv); w = 11'(wv); h = 11'(hv); color = cv; outline = ol;
      start = 1'b1;
      @(negedge clk);
      // scramble command inputs: the DUT must work from its latched copy
      x0 = 10'($urandom); y0 = 10'($urandom); w = 11'($urandom); h = 11'($urandom);
      color = 16'($urandom); outline = 1'($urandom);
      k = 1;
      forever begin
         start = 1'b0;
         if (busy) r_busy_cyc++;
         if (we !== stb) r_we_bad++;
         if (done === 1'b1) begin r_done_k = k; break; end
         if (k > 5000) begin r_tmo = 1; break; end
         if (stb) begin
            r_stb_cyc++;
            if (wc > 0 && (addr !== ha || data_out !== hd)) r_unstable++;
            ha = addr; hd = data_out;
            if (wc == lat - 1) begin
               ack = 1'b1; got_a.push_back(addr); got_d.push_back(data_out); wc = 0;
            end else begin
               ack = 1'b0; wc++;
            end
            if (poke && k == 4) begin
               start = 1'b1; x0 = 10'd0; y0 = 10'd0; w = 11'd50; h = 11'd50;
            end
         end else begin
            ack = 1'($urandom_range(0, 1));  // stray ack with no request
         end
         @(negedge clk); k++;
      end
      ack = 1'b0;
      @(negedge clk);
      r_done_w = done;
      r_idle_busy = busy;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; ack = 1'b0; outline = 1'b0;
      x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_chk++; if (stb !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b/%b exp 0/0", stb, we); end
      n_chk++; if (addr !== 20'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", addr); end
      n_chk++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_out); end
      n_chk++; if (pix_cnt !== 20'h0) begin n_fail++; $display("FAIL reset_pix_cnt got %0d exp 0", pix_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      model(10, 20, 3, 2, 1'b0);
      drive_fill(10, 20, 3, 2, 16'h7C00, 1'b0, 1, 1'b0);
      n_chk++; if (r_tmo) begin n_fail++; $display("FAIL basic_timeout got no done exp done"); end
      n_chk++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL basic_count got %0d exp %0d", got_a.size(), exp_a.size()); end
      foreach (exp_a[i]) begin
         n_chk++;
         if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
            n_fail++; $display("FAIL basic_addr[%0d] got %h exp %h", i, (i < got_a.size()) ? got_a[i] : 20'hx, exp_a[i]);
         end
      end
      foreach (got_d[i]) begin
         n_chk++; if (got_d[i] !== 32'h00007C00) begin n_fail++; $display("FAIL basic_data[%0d] got %h exp 00007c00", i, got_d[i]); end
      end
      n_chk++; if (pix_cnt !== 20'd6) begin n_fail++; $display("FAIL basic_pix_cnt got %0d exp 6", pix_cnt); end
      n_chk++; if (r_done_k != 8) begin n_fail++; $display("FAIL basic_latency got %0d exp 8", r_done_k); end
      n_chk++; if (r_done_w !== 1'b0 || r_idle_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got done=%b busy=%b exp 0/0", r_done_w, r_idle_busy); end
      n_chk++; if (r_we_bad != 0) begin n_fail++; $display("FAIL basic_we got %0d mismatched cycles exp 0", r_we_bad); end
   endtask

   task automatic test_empty;
      int cases[3][4] = '{'{5, 5, 0, 7}, '{5, 5, 7, 0}, '{5, 800, 4, 4}};
      foreach (cases[c]) begin
         drive_fill(cases[c][0], cases[c][1], cases[c][2], cases[c][3], 16'h1234, 1'b0, 1, 1'b0);
         n_chk++; if (r_stb_cyc != 0) begin n_fail++; $display("FAIL empty%0d_stb got %0d exp 0", c, r_stb_cyc); end
         n_chk++; if (r_busy_cyc != 2 || r_done_k != 2) begin n_fail++; $display("FAIL empty%0d_busy got busy=%0d done_at=%0d exp 2/2", c, r_busy_cyc, r_done_k); end
         n_chk++; if (pix_cnt !== 20'd0) begin n_fail++; $display("FAIL empty%0d_pix_cnt got %0d exp 0", c, pix_cnt); end
      end
   endtask

   task automatic test_corner;
      int cases[2][4] = '{'{1022, 766, 5, 5}, '{1023, 100, 1024, 3}};
      foreach (cases[c]) begin
         model(cases[c][0], cases[c][1], cases[c][2], cases[c][3], 1'b0);
         drive_fill(cases[c][0], cases[c][1], cases[c][2], cases[c][3], 16'h03E0, 1'b0, 2, 1'b0);
         n_chk++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL corner%0d_count got %0d exp %0d", c, got_a.size(), exp_a.size()); end
         foreach (exp_a[i]) begin
            n_chk++;
            if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
               n_fail++; $display("FAIL corner%0d_addr[%0d] got %h exp %h", c, i, (i < got_a.size()) ? got_a[i] : 20'hx, exp_a[i]);
            end
         end
         n_chk++; if (pix_cnt !== 20'(exp_a.size())) begin n_fail++; $display("FAIL corner%0d_pix_cnt got %0d exp %0d", c, pix_cnt, exp_a.size()); end
      end
   endtask

   task automatic test_stall;
      model(5, 5, 3, 2, 1'b0);
      drive_fill(5, 5, 3, 2, 16'h001F, 1'b0, 4, 1'b1);
      n_chk++; if (r_unstable != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes exp 0", r_unstable); end
      n_chk++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", got_a.size(), exp_a.size()); end
      foreach (exp_a[i]) begin
         n_chk++;
         if (i >= got_a.size() || got_a[i] !== exp_a[i]) begin
            n_fail++; $display("FAIL stall_addr[%0d] got %h exp %h", i, (i < got_a.size()) ? got_a[i] : 20'hx, exp_a[i]);
         end
      end
      n_chk++; if (r_done_k != 2 + 6 * 4) begin n_fail++; $display("FAIL stall_latency got %0d exp %0d", r_done_k, 2 + 6 * 4); end
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b0 || pix_cnt !== 20'd6) begin n_fail++; $display("FAIL stall_ignored_start got busy=%b pix_cnt=%0d exp 0/6", busy, pix_cnt); end
   endtask

   task automatic test_reset_mid;
      int acks = 0;
      bit hit = 0;
      @(negedge clk);
      x0 = 10'd0; y0 = 10'd0; w = 11'd10; h = 11'd10; color = 16'h5555; outline = 1'b0;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (stb) begin
            if (acks == 2) begin rst_n = 1'b0; ack = 1'b0; hit = 1; break; end
            ack = 1'b1; acks++;
         end else ack = 1'b0;
         @(negedge clk);
      end
      ack = 1'b0;
      n_chk++; if (!hit) begin n_fail++; $display("FAIL rstmid_timeout got %0d acks exp third write", acks); end
      @(negedge clk);
      n_chk++; if (stb !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got stb=%b busy=%b exp 0/0", stb, busy); end
      n_chk++; if (pix_cnt !== 20'd0) begin n_fail++; $display("FAIL rstmid_pix_cnt got %0d exp 0", pix_cnt); end
      rst_n = 1'b1;
      model(3, 4, 2, 2, 1'b0);
      drive_fill(3, 4, 2, 2, 16'h0F0F, 1'b0, 1, 1'b0);
      n_chk++; if (got_a != exp_a) begin n_fail++; $display("FAIL rstmid_refill got %0d writes exp %0d", got_a.size(), exp_a.size()); end
      n_chk++; if (pix_cnt !== 20'd4 || got_d[0] !== 32'h00000F0F) begin n_fail++; $display("FAIL rstmid_refill_cnt got %0d exp 4", pix_cnt); end
   endtask

   task automatic test_random;
      for (int it = 0; it < 12; it++) begin
         int xv, yv, wv, hv, lat;
         bit ol;
         xv = $urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(1010, 1023);
         yv = $urandom_range(0, 1) ? $urandom_range(0, 780) : $urandom_range(760, 1023);
         wv = $urandom_range(0, 3) == 0 ? $urandom_range(0, 1024) : $urandom_range(0, 12);
         hv = $urandom_range(0, 6);
         if (wv > 12 && xv < 1000) xv = 1000;  // keep long runs short
         lat = $urandom_range(1, 3);
         ol = HAS_OL ? 1'($urandom_range(0, 1)) : 1'b0;
         model(xv, yv, wv, hv, ol);
         drive_fill(xv, yv, wv, hv, 16'($urandom), ol, lat, 1'b0);
         n_chk++;
         if (got_a != exp_a || r_tmo) begin
            n_fail++; $display("FAIL rand%0d_addrs got %0d writes exp %0d (x0=%0d y0=%0d w=%0d h=%0d ol=%0d)",
                               it, got_a.size(), exp_a.size(), xv, yv, wv, hv, ol);
         end
         n_chk++; if (pix_cnt !== 20'(exp_a.size())) begin n_fail++; $display("FAIL rand%0d_pix_cnt got %0d exp %0d", it, pix_cnt, exp_a.size()); end
         n_chk++; if (r_done_k != 2 + exp_a.size() * lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d exp %0d", it, r_done_k, 2 + exp_a.size() * lat); end
      end
   endtask

`ifdef HCV_FILL_OUTLINE_EN
   task automatic test_outline;
      logic [19:0] ref_a[$];
      ref_a = '{{10'd0,10'd0}, {10'd0,10'd1}, {10'd0,10'd2}, {10'd0,10'd3},
                {10'd1,10'd0}, {10'd1,10'd3},
                {10'd2,10'd0}, {10'd2,10'd1}, {10'd2,10'd2}, {10'd2,10'd3}};
      drive_fill(0, 0, 4, 3, 16'h7FFF, 1'b1, 1, 1'b0);
      n_chk++; if (got_a != ref_a) begin n_fail++; $display("FAIL outline_addrs got %0d writes exp 10", got_a.size()); end
      n_chk++; if (pix_cnt !== 20'd10) begin n_fail++; $display("FAIL outline_pix_cnt got %0d exp 10", pix_cnt); end
      model(1023, 10, 1024, 4, 1'b1);
      drive_fill(1023, 10, 1024, 4, 16'h7FFF, 1'b1, 1, 1'b0);
      n_chk++; if (got_a != exp_a || pix_cnt !== 20'd4) begin n_fail++; $display("FAIL outline_column got %0d writes exp %0d", got_a.size(), exp_a.size()); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_corner();
      test_stall();
      test_reset_mid();
      test_random();
`ifdef HCV_FILL_OUTLINE_EN
      test_outline();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
